// File: rtl/pkt_check.sv
// pkt_check: receive-side checker for the counting-packet stream.
// Locks on a header beat, checks each lane's counting sequence and the
// packet length, and keeps saturating counters for software readout.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   en, din_valid    a beat is taken when both are high
//   burst_len        expected data beats per packet minus 1
//   din              lane i = din[DIN_WIDTH*i +: DIN_WIDTH]
//   in_packet        high while locked inside a packet
//   pkt_done/pkt_ok  close pulse and its pass/fail qualifier
//   last_len         data-beat count of the last closed packet
//   *_count          saturating packet / error counters
//   first_err_*      first-error capture (tied to 0 unless enabled)
//
// Build option: define PKT_CHECK_ERR_CAPTURE_EN to build the
// first-error capture registers.

module pkt_check #(
    parameter int          DIN_WIDTH = 32,
    parameter int          PARALLEL  = 4,
    parameter logic [31:0] HEADER    = 32'haabbccdd
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [31:0]                   burst_len,
    input  logic [DIN_WIDTH*PARALLEL-1:0] din,
    input  logic                          din_valid,
    output logic                          in_packet,
    output logic                          pkt_done,
    output logic                          pkt_ok,
    output logic [31:0]                   last_len,
    output logic [31:0]                   pkt_count,
    output logic [31:0]                   data_err_count,
    output logic [31:0]                   len_err_count,
    output logic [31:0]                   sync_err_count,
    output logic [31:0]                   first_err_beat,
    output logic [PARALLEL-1:0]           first_err_lanes,
    output logic [DIN_WIDTH-1:0]          first_err_word
);

    localparam logic [DIN_WIDTH-1:0] HDR  = HEADER[DIN_WIDTH-1:0];
    localparam logic [DIN_WIDTH-1:0] STEP = DIN_WIDTH'(PARALLEL);

    typedef enum logic {IDLE, DATA} state_e;

    state_e               state_q;
    logic [DIN_WIDTH-1:0] exp_q [PARALLEL];
    logic [31:0]          beats_q;
    logic                 err_q;
    logic                 done_q;
    logic                 ok_q;
    logic [31:0]          len_q;
    logic [31:0]          pkts_q;
    logic [31:0]          derr_q;
    logic [31:0]          lerr_q;
    logic [31:0]          serr_q;

    logic [DIN_WIDTH-1:0] lane [PARALLEL];
    logic [PARALLEL-1:0]  mism;
    logic                 beat;
    logic                 hdr;
    logic                 close;
    logic                 len_ok;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hffffffff) ? v : v + 32'd1;
    endfunction

    always_comb begin
        hdr = 1'b1;
        for (int i = 0; i < PARALLEL; i++) begin
            lane[i] = din[DIN_WIDTH*i +: DIN_WIDTH];
            mism[i] = (lane[i] != exp_q[i]);
            hdr     = hdr & (lane[i] == HDR);
        end
        beat  = en & din_valid;
        hdr   = hdr & beat;
        // A packet closes on a gap or on a fresh header while in DATA.
        close = (state_q == DATA) & en & (!din_valid | hdr);
        // 33-bit compare so burst_len = all-ones can never match.
        len_ok = ({1'b0, beats_q} == ({1'b0, burst_len} + 33'd1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < PARALLEL; i++) exp_q[i] <= '0;
            beats_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            len_q   <= '0;
            pkts_q  <= '0;
            derr_q  <= '0;
            lerr_q  <= '0;
            serr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (close) begin
                done_q <= 1'b1;
                ok_q   <= !err_q & len_ok;
                len_q  <= beats_q;
                pkts_q <= sat_inc(pkts_q);
                if (!len_ok) lerr_q <= sat_inc(lerr_q);
            end
            if (hdr) begin
                state_q <= DATA;
                for (int i = 0; i < PARALLEL; i++)
                    exp_q[i] <= DIN_WIDTH'(i);
                beats_q <= '0;
                err_q   <= 1'b0;
            end else if (en && !din_valid) begin
                state_q <= IDLE;
            end else if (beat && state_q == IDLE) begin
                serr_q <= sat_inc(serr_q);
            end else if (beat) begin
                if (|mism) begin
                    derr_q <= sat_inc(derr_q);
                    err_q  <= 1'b1;
                end
                // No resync: the sequence advances even on a bad beat.
                for (int i = 0; i < PARALLEL; i++)
                    exp_q[i] <= exp_q[i] + STEP;
                beats_q <= sat_inc(beats_q);
            end
        end
    end

    assign in_packet      = (state_q == DATA);
    assign pkt_done       = done_q;
    assign pkt_ok         = ok_q;
    assign last_len       = len_q;
    assign pkt_count      = pkts_q;
    assign data_err_count = derr_q;
    assign len_err_count  = lerr_q;
    assign sync_err_count = serr_q;

`ifdef PKT_CHECK_ERR_CAPTURE_EN
    logic                 cap_q;
    logic [31:0]          fbeat_q;
    logic [PARALLEL-1:0]  flanes_q;
    logic [DIN_WIDTH-1:0] fword_q;
    logic [DIN_WIDTH-1:0] fword_d;

    // Received value of the lowest-numbered mismatching lane.
    always_comb begin
        fword_d = '0;
        for (int i = PARALLEL - 1; i >= 0; i--)
            if (mism[i]) fword_d = lane[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q    <= 1'b0;
            fbeat_q  <= '0;
            flanes_q <= '0;
            fword_q  <= '0;
        end else if (beat && !hdr && state_q == DATA
                     && |mism && !cap_q) begin
            cap_q    <= 1'b1;
            fbeat_q  <= beats_q;
            flanes_q <= mism;
            fword_q  <= fword_d;
        end
    end

    assign first_err_beat  = fbeat_q;
    assign first_err_lanes = flanes_q;
    assign first_err_word  = fword_q;
`else
    assign first_err_beat  = '0;
    assign first_err_lanes = '0;
    assign first_err_word  = '0;
`endif

endmodule
